nes_pad_reader: RTL

NES_PAD_READER -- requirements
Module: nes_pad_reader

---
 rtl/nes_pkg.sv | 29 ++
 rtl/nes_tick_gen.sv | 47 ++++
 rtl/nes_pad_reader.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/nes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nes_pkg
// Description : Shared types and protocol constants for the NES/SNES pad
//               reader: controller state enum, frame lengths and a counter
//               width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package nes_pkg;

  // Frame lengths of the two supported controller families.
  localparam int NES_BITS  = 8;
  localparam int SNES_BITS = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_LOW   = 3'd2,
    ST_HIGH  = 3'd3,
    ST_DONE  = 3'd4
  } nes_state_e;

  // Width of a counter that must hold 0..n-1 (never narrower than one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nes_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : nes_tick_gen
// Description : Phase counter for the pad protocol. Counts 0..CLK_DIV-1 and
//               flags the last cycle of every phase; held at zero by clear.
// Ports       : clk   - system clock
//               rst   - synchronous active-high reset
//               clear - hold counter at zero (no phase in progress)
//               tick  - high on the last cycle of the current phase
// Revision    : 1.0 - initial release
// ============================================================================
module nes_tick_gen
  import nes_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = cnt_width(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Gated by clear so CLK_DIV=1 does not tick while idle.
  assign tick = (cnt_q == LAST) && !clear;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/nes_pad_reader.sv
`default_nettype none
// ============================================================================
// Module      : nes_pad_reader
// Description : Reads NUM_PADS NES/SNES controllers in parallel. Generates
//               latch/clock, shifts the active-low serial data in, and
//               publishes held button state plus press/release pulses.
//               Optional macro NES_DEBOUNCE_EN: a button bit only changes
//               when the two most recent frames agree on it.
// Ports       : clk, rst (sync, active-high), poll_req (on-demand poll),
//               pad_data[NUM_PADS] (active-low serial in),
//               pad_latch, pad_clock (to pads, clock idles high),
//               buttons/pressed/released[NUM_PADS*NUM_BITS] (pad p bit i at
//               p*NUM_BITS+i), valid (buttons updated), busy (frame running)
// Revision    : 1.0 - initial release
// ============================================================================
module nes_pad_reader
  import nes_pkg::*;
#(
  parameter int NUM_PADS    = 2,       // 1..4
  parameter int NUM_BITS    = 8,       // NES_BITS or SNES_BITS only
  parameter int CLK_DIV     = 25,
  parameter int POLL_CYCLES = 833333   // 0 disables the auto-poll timer
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         poll_req,
  input  logic [NUM_PADS-1:0]          pad_data,
  output logic                         pad_latch,
  output logic                         pad_clock,
  output logic [NUM_PADS*NUM_BITS-1:0] buttons,
  output logic [NUM_PADS*NUM_BITS-1:0] pressed,
  output logic [NUM_PADS*NUM_BITS-1:0] released,
  output logic                         valid,
  output logic                         busy
);

  localparam int W     = NUM_PADS * NUM_BITS;
  localparam int IDX_W = cnt_width(NUM_BITS);

  nes_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             pending_q, pending_d;
  logic [W-1:0]     sh_q, sh_d;
  logic [W-1:0]     buttons_q, buttons_d;
  logic [W-1:0]     pressed_q, pressed_d;
  logic [W-1:0]     released_q, released_d;
  logic             valid_q, valid_d;
  logic             pad_latch_q, pad_latch_d;
  logic             pad_clock_q, pad_clock_d;
  logic             busy_q, busy_d;

  logic             tick;
  logic             tick_clear;
  logic             poll_tc;
  logic             start_evt;
  logic [W-1:0]     frame_btn;

  // The phase counter only runs inside the timed phases.
  assign tick_clear = (state_q == ST_IDLE) || (state_q == ST_DONE);

  nes_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (tick_clear),
    .tick  (tick)
  );

  // Free-running auto-poll timer.
  generate
    if (POLL_CYCLES > 0) begin : g_poll_timer
      localparam int PW = cnt_width(POLL_CYCLES);
      logic [PW-1:0] poll_cnt_q, poll_cnt_d;

      assign poll_tc = (poll_cnt_q == PW'(POLL_CYCLES - 1));

      always_comb begin
        poll_cnt_d = poll_tc ? '0 : poll_cnt_q + 1'b1;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          poll_cnt_q <= '0;
        end else begin
          poll_cnt_q <= poll_cnt_d;
        end
      end
    end else begin : g_no_poll_timer
      assign poll_tc = 1'b0;
    end
  endgenerate

  // A simultaneous request and timer expiry is a single event.
  assign start_evt = poll_req | poll_tc;

`ifdef NES_DEBOUNCE_EN
  logic [W-1:0] prev_q, prev_d;

  // Bits where this frame matches the previous one take the new value,
  // disagreeing bits keep the published state.
  assign frame_btn = (sh_q & prev_q) | (buttons_q & (sh_q ^ prev_q));

  always_comb begin
    prev_d = prev_q;
    if (state_q == ST_DONE) begin
      prev_d = sh_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
    end else begin
      prev_q <= prev_d;
    end
  end
`else
  assign frame_btn = sh_q;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pending_d  = pending_q;
    sh_d       = sh_q;
    buttons_d  = buttons_q;
    pressed_d  = '0;
    released_d = '0;
    valid_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        idx_d     = '0;
        pending_d = 1'b0;
        if (start_evt || pending_q) begin
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        if (start_evt) pending_d = 1'b1;
        // Latch spans two phases; idx marks the first one as done.
        if (tick) begin
          if (idx_q == '0) begin
            idx_d = IDX_W'(1);
          end else begin
            idx_d   = '0;
            state_d = ST_LOW;
          end
        end
      end
      ST_LOW: begin
        if (start_evt) pending_d = 1'b1;
        if (tick) begin
          // First bit shifted ends up at bit 0 after NUM_BITS shifts.
          for (int p = 0; p < NUM_PADS; p++) begin
            sh_d[p*NUM_BITS +: NUM_BITS] =
              {~pad_data[p], sh_q[p*NUM_BITS+1 +: NUM_BITS-1]};
          end
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (start_evt) pending_d = 1'b1;
        if (tick) begin
          if (idx_q == IDX_W'(NUM_BITS - 1)) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_LOW;
          end
        end
      end
      ST_DONE: begin
        buttons_d  = frame_btn;
        pressed_d  = frame_btn & ~buttons_q;
        released_d = ~frame_btn & buttons_q;
        valid_d    = 1'b1;
        idx_d      = '0;
        pending_d  = 1'b0;
        state_d    = (start_evt || pending_q) ? ST_LATCH : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pin outputs are registered from the next state so they align with it.
  always_comb begin
    pad_latch_d = (state_d == ST_LATCH);
    pad_clock_d = (state_d != ST_LOW);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      pending_q   <= 1'b0;
      sh_q        <= '0;
      buttons_q   <= '0;
      pressed_q   <= '0;
      released_q  <= '0;
      valid_q     <= 1'b0;
      pad_latch_q <= 1'b0;
      pad_clock_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pending_q   <= pending_d;
      sh_q        <= sh_d;
      buttons_q   <= buttons_d;
      pressed_q   <= pressed_d;
      released_q  <= released_d;
      valid_q     <= valid_d;
      pad_latch_q <= pad_latch_d;
      pad_clock_q <= pad_clock_d;
      busy_q      <= busy_d;
    end
  end

  assign pad_latch = pad_latch_q;
  assign pad_clock = pad_clock_q;
  assign buttons   = buttons_q;
  assign pressed   = pressed_q;
  assign released  = released_q;
  assign valid     = valid_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire
